// File: rtl/upscale_pkg.sv
// upscale_pkg: shared types and helpers for the 2x-per-axis upscaler.
//   state_t  : frame sequencer states
//   avg()    : pixel average, evaluated at AVG_W bits and truncated by the caller
// Build option: UPSCALE_ROUND_EN selects rounding averages (a+b+1)>>1;
// default build uses the truncating (a>>1)+(b>>1) form.
package upscale_pkg;

    typedef enum logic [2:0] {
        IDLE, LOAD0, LOAD, EVEN, ODD, EVEN_LAST, ODD_LAST
    } state_t;

    localparam int DEF_BIT_DEPTH = 8;
    localparam int DEF_MAX_W     = 64;
    localparam int DEF_MAX_H     = 64;

    // Widest pixel the shared average supports; callers zero-extend into it.
    localparam int AVG_W = 16;

    function automatic logic [AVG_W-1:0] avg(input logic [AVG_W-1:0] a,
                                             input logic [AVG_W-1:0] b);
`ifdef UPSCALE_ROUND_EN
        logic [AVG_W:0] s;
        s = {1'b0, a} + {1'b0, b} + {{AVG_W{1'b0}}, 1'b1};
        return s[AVG_W:1];
`else
        return (a >> 1) + (b >> 1);
`endif
    endfunction

endpackage

// File: rtl/upscale_line_buf.sv
// upscale_line_buf: ping-pong line storage, two MAX_W x BIT_DEPTH flop banks.
//   i_clk                 clock
//   i_sel                 swaps which physical bank is logical A
//   i_wr_en/i_wr_b        write strobe; i_wr_b=0 writes A, 1 writes B
//   i_wr_addr/i_wr_data   write column / pixel
//   i_rd_x, i_last_x      read column and W-1 (clamp for the x+1 port)
//   o_a0/o_a1, o_b0/o_b1  A[x], A[x+1], B[x], B[x+1] (x+1 clamped)
// Contents are intentionally not reset.
module upscale_line_buf #(
    parameter int BIT_DEPTH = 8,
    parameter int MAX_W     = 64,
    parameter int AW        = 6
) (
    input  logic                 i_clk,
    input  logic                 i_sel,
    input  logic                 i_wr_en,
    input  logic                 i_wr_b,
    input  logic [AW-1:0]        i_wr_addr,
    input  logic [BIT_DEPTH-1:0] i_wr_data,
    input  logic [AW-1:0]        i_rd_x,
    input  logic [AW-1:0]        i_last_x,
    output logic [BIT_DEPTH-1:0] o_a0,
    output logic [BIT_DEPTH-1:0] o_a1,
    output logic [BIT_DEPTH-1:0] o_b0,
    output logic [BIT_DEPTH-1:0] o_b1
);

    logic [BIT_DEPTH-1:0] r_bank [2][MAX_W];
    logic [AW-1:0]        w_xn;
    logic                 w_wr_bank;

    assign w_wr_bank = i_wr_b ? ~i_sel : i_sel;
    assign w_xn      = (i_rd_x == i_last_x) ? i_rd_x : i_rd_x + AW'(1);

    always_ff @(posedge i_clk) begin
        if (i_wr_en) r_bank[w_wr_bank][i_wr_addr] <= i_wr_data;
    end

    assign o_a0 = r_bank[i_sel][i_rd_x];
    assign o_a1 = r_bank[i_sel][w_xn];
    assign o_b0 = r_bank[~i_sel][i_rd_x];
    assign o_b1 = r_bank[~i_sel][w_xn];

endmodule

// File: rtl/upscale_ctrl.sv
// upscale_ctrl: frame sequencer for the 2x-per-axis upscaler.
// Takes a W x H row-major stream, emits 2W x 2H: even rows are real rows,
// odd rows vertical averages, both horizontally interpolated with the last
// pixel of each row repeated. Bottom output row repeats the last real row.
//   clk, reset          clock, synchronous active-high reset
//   start,width,height  frame start pulse and geometry (sampled when idle)
//   in_valid/in_ready/in_data                 input pixel stream
//   out_valid/out_ready/out_data/out_eol/out_eof output pixel stream
//   busy, done, cfg_err frame status; done/cfg_err are 1-cycle pulses
// Build option: UPSCALE_ROUND_EN (rounding averages, see upscale_pkg).
module upscale_ctrl
    import upscale_pkg::*;
#(
    parameter int BIT_DEPTH = DEF_BIT_DEPTH,
    parameter int MAX_W     = DEF_MAX_W,
    parameter int MAX_H     = DEF_MAX_H
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [$clog2(MAX_W+1)-1:0]   width,
    input  logic [$clog2(MAX_H+1)-1:0]   height,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [BIT_DEPTH-1:0]         in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BIT_DEPTH-1:0]         out_data,
    output logic                         out_eol,
    output logic                         out_eof,
    output logic                         busy,
    output logic                         done,
    output logic                         cfg_err
);

    localparam int WW = $clog2(MAX_W+1);
    localparam int HW = $clog2(MAX_H+1);
    localparam int AW = $clog2(MAX_W);
    localparam int CW = WW + 1;           // column counter spans 0..2W-1

    function automatic logic [BIT_DEPTH-1:0] pavg(input logic [BIT_DEPTH-1:0] a,
                                                  input logic [BIT_DEPTH-1:0] b);
        return BIT_DEPTH'(avg(AVG_W'(a), AVG_W'(b)));
    endfunction

    state_t               r_state, w_next;
    logic [WW-1:0]        r_w;
    logic [HW-1:0]        r_h, r_rows;
    logic [CW-1:0]        r_col;
    logic                 r_sel, r_done, r_cfg_err;
    logic                 w_in_rdy, w_out_vld, w_in_hs, w_out_hs;
    logic                 w_load_last, w_row_last, w_cfg_bad;
    logic [AW-1:0]        w_x, w_last_x;
    logic [BIT_DEPTH-1:0] w_a0, w_a1, w_b0, w_b1, w_p0, w_p1, w_pix;

    assign w_load_last = (r_col == {1'b0, r_w} - CW'(1));
    assign w_row_last  = (r_col == {r_w, 1'b0} - CW'(1));
    assign w_cfg_bad   = (width == '0) || (width > WW'(MAX_W)) ||
                         (height == '0) || (height > HW'(MAX_H));

    // Handshakes are folded in as in_valid/out_ready because ready/valid
    // are themselves decoded here; this keeps the block loop-free.
    always_comb begin
        w_next    = r_state;
        w_in_rdy  = 1'b0;
        w_out_vld = 1'b0;
        case (r_state)
            IDLE:      if (start && !w_cfg_bad) w_next = LOAD0;
            LOAD0: begin
                w_in_rdy = 1'b1;
                if (in_valid && w_load_last) w_next = (r_h == HW'(1)) ? EVEN_LAST : LOAD;
            end
            LOAD: begin
                w_in_rdy = 1'b1;
                if (in_valid && w_load_last) w_next = EVEN;
            end
            EVEN: begin
                w_out_vld = 1'b1;
                if (out_ready && w_row_last) w_next = ODD;
            end
            ODD: begin
                w_out_vld = 1'b1;
                if (out_ready && w_row_last) w_next = (r_rows == r_h) ? EVEN_LAST : LOAD;
            end
            EVEN_LAST: begin
                w_out_vld = 1'b1;
                if (out_ready && w_row_last) w_next = ODD_LAST;
            end
            ODD_LAST: begin
                w_out_vld = 1'b1;
                if (out_ready && w_row_last) w_next = IDLE;
            end
            default:   w_next = IDLE;
        endcase
    end

    assign w_in_hs  = in_valid && w_in_rdy;
    assign w_out_hs = w_out_vld && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_w       <= '0;
            r_h       <= '0;
            r_rows    <= '0;
            r_col     <= '0;
            r_sel     <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            if (r_state == IDLE && start) begin
                if (w_cfg_bad) begin
                    r_cfg_err <= 1'b1;
                end else begin
                    r_w    <= width;
                    r_h    <= height;
                    r_rows <= '0;
                    r_col  <= '0;
                    r_sel  <= 1'b0;
                end
            end
            if (w_in_hs) begin
                if (w_load_last) begin
                    r_col  <= '0;
                    r_rows <= r_rows + HW'(1);
                end else begin
                    r_col  <= r_col + CW'(1);
                end
            end
            if (w_out_hs) begin
                if (w_row_last) begin
                    r_col <= '0;
                    // After an averaged row the newer row becomes the top row.
                    if (r_state == ODD)      r_sel  <= ~r_sel;
                    if (r_state == ODD_LAST) r_done <= 1'b1;
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
        end
    end

    assign w_x      = r_col[AW:1];
    assign w_last_x = AW'(r_w - WW'(1));

    upscale_line_buf #(.BIT_DEPTH(BIT_DEPTH), .MAX_W(MAX_W), .AW(AW)) u_buf (
        .i_clk     (clk),
        .i_sel     (r_sel),
        .i_wr_en   (w_in_hs),
        .i_wr_b    (r_state == LOAD),
        .i_wr_addr (r_col[AW-1:0]),
        .i_wr_data (in_data),
        .i_rd_x    (w_x),
        .i_last_x  (w_last_x),
        .o_a0      (w_a0),
        .o_a1      (w_a1),
        .o_b0      (w_b0),
        .o_b1      (w_b1)
    );

    // Vertical stage only in ODD; the bottom replicated row reads A alone.
    assign w_p0 = (r_state == ODD) ? pavg(w_a0, w_b0) : w_a0;
    assign w_p1 = (r_state == ODD) ? pavg(w_a1, w_b1) : w_a1;
    // The last column repeats its pixel raw: avg(p,p) would lose the LSB.
    assign w_pix = (!r_col[0] || (w_x == w_last_x)) ? w_p0 : pavg(w_p0, w_p1);

    assign in_ready  = w_in_rdy;
    assign out_valid = w_out_vld;
    assign out_data  = w_out_vld ? w_pix : '0;
    assign out_eol   = w_out_vld && w_row_last;
    assign out_eof   = (r_state == ODD_LAST) && w_row_last;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_upscale_ctrl.sv
module tb_upscale_ctrl;

    logic       clk = 1'b0, reset = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [6:0] width = '0, height = '0;
    logic [7:0] in_data = '0;
    logic       in_ready, out_valid, out_eol, out_eof, busy, done, cfg_err;
    logic [7:0] out_data;

    upscale_ctrl #(.BIT_DEPTH(8), .MAX_W(64), .MAX_H(64)) dut (
        .clk(clk), .reset(reset), .start(start), .width(width), .height(height),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_eol(out_eol), .out_eof(out_eof), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct { int d; int eol; int eof; } exp_t;
    exp_t exp_q[$];
    int   img [8][8];
    int   errors = 0, checks = 0;
    int   n_out = 0, done_cnt = 0;
    bit   stall_mode = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int tavg(input int a, input int b);
`ifdef UPSCALE_ROUND_EN
        return (a + b + 1) / 2;
`else
        return a / 2 + b / 2;
`endif
    endfunction

    // Output frame straight from the rules: row r uses real row r/2 when even
    // (or when no row below exists), otherwise the vertical average; then
    // interpolate horizontally with the last pixel repeated.
    task automatic build(input int w, input int h);
        int v [8];
        exp_q.delete();
        for (int r = 0; r < 2*h; r++) begin
            int rs;
            rs = r / 2;
            for (int x = 0; x < w; x++)
                v[x] = (r % 2 == 0 || rs + 1 >= h) ? img[rs][x] : tavg(img[rs][x], img[rs+1][x]);
            for (int c = 0; c < 2*w; c++) begin
                exp_t e;
                int   x;
                x = c / 2;
                e.d   = (c % 2 == 0 || x == w - 1) ? v[x] : tavg(v[x], v[x+1]);
                e.eol = (c == 2*w - 1) ? 1 : 0;
                e.eof = (c == 2*w - 1 && r == 2*h - 1) ? 1 : 0;
                exp_q.push_back(e);
            end
        end
    endtask

    // Single compare process for the output stream and its timing rules.
    bit   p_stall = 0, p_vld = 0, p_in_hs = 0, p_eof_hs = 0;
    int   p_d = 0, p_eol = 0, p_eof = 0;
    always @(negedge clk) begin
        if (reset) begin
            p_stall = 0; p_vld = 0; p_in_hs = 0; p_eof_hs = 0;
        end else begin
            if (out_valid) chk("in_ready_during_emit", int'(in_ready), 0);
            if (p_stall) begin
                chk("stall_valid_hold", int'(out_valid), 1);
                chk("stall_data_hold", int'(out_data), p_d);
                chk("stall_eol_hold", int'(out_eol), p_eol);
                chk("stall_eof_hold", int'(out_eof), p_eof);
            end
            if (out_valid && !p_vld) chk("first_out_latency", int'(p_in_hs), 1);
            if (done) begin
                done_cnt++;
                chk("done_after_eof", int'(p_eof_hs), 1);
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) chk("extra_output", 1, 0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pix", int'(out_data), e.d);
                    chk("eol", int'(out_eol), e.eol);
                    chk("eof", int'(out_eof), e.eof);
                end
            end
            p_stall  = out_valid && !out_ready;
            p_d      = int'(out_data);
            p_eol    = int'(out_eol);
            p_eof    = int'(out_eof);
            p_vld    = out_valid;
            p_in_hs  = in_valid && in_ready;
            p_eof_hs = out_valid && out_ready && out_eof;
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = stall_mode ? ~out_ready : 1'b1;
        end
    end

    task automatic do_start(input int w, input int h);
        @(posedge clk); #1;
        width = 7'(w); height = 7'(h); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input int w, input int h);
        for (int i = 0; i < w*h; i++) begin
            int k;
            in_data  = 8'(img[i/w][i%w]);
            in_valid = 1'b1;
            k = 0;
            @(negedge clk);
            while (!in_ready && k < 500) begin k++; @(negedge clk); end
            if (!in_ready) chk("feed_timeout", 0, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < 2000) begin k++; @(negedge clk); end
        chk("frame_end_timeout", int'(busy), 0);
        @(posedge clk); #1;
    endtask

    task automatic run_frame(input int w, input int h, input bit stall, input bit poke);
        stall_mode = stall;
        build(w, h);
        done_cnt = 0; n_out = 0;
        do_start(w, h);
        chk("busy_after_start", int'(busy), 1);
        feed(w, h);
        if (poke) begin
            // start while busy (even with a bad width) must be ignored silently
            @(posedge clk); #1; width = 7'd0; start = 1'b1;
            @(posedge clk); #1; start = 1'b0;
            chk("start_busy_no_err", int'(cfg_err), 0);
            chk("start_busy_still_busy", int'(busy), 1);
        end
        wait_idle();
        chk("done_count", done_cnt, 1);
        chk("outputs_remaining", exp_q.size(), 0);
        chk("output_count", n_out, 4*w*h);
        stall_mode = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_in_ready"}, int'(in_ready), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_cfg_err"}, int'(cfg_err), 0);
        chk({tag, "_eol"}, int'(out_eol), 0);
        chk({tag, "_eof"}, int'(out_eof), 0);
        chk({tag, "_data"}, int'(out_data), 0);
    endtask

    task automatic set_case1();
        img[0][0] = 10; img[0][1] = 20; img[1][0] = 30; img[1][1] = 40;
    endtask

    int lit1 [16] = '{10,15,20,20, 20,25,30,30, 30,35,40,40, 30,35,40,40};
`ifdef UPSCALE_ROUND_EN
    int lit2 [8]  = '{11,12,12,12, 11,12,12,12};
`else
    int lit2 [8]  = '{11,11,12,12, 11,11,12,12};
`endif

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        reset = 1'b0;

        // Model pins against hand-computed frames.
        set_case1();
        build(2, 2);
        for (int i = 0; i < 16; i++) chk("model_case1", exp_q[i].d, lit1[i]);
        chk("model_case1_eol3", exp_q[3].eol, 1);
        chk("model_case1_eof15", exp_q[15].eof, 1);
        img[0][0] = 11; img[0][1] = 12;
        build(2, 1);
        for (int i = 0; i < 8; i++) chk("model_case2", exp_q[i].d, lit2[i]);
        img[0][0] = 200;
        build(1, 1);
        for (int i = 0; i < 4; i++) chk("model_case3", exp_q[i].d, 200);
        chk("model_case3_eof", exp_q[3].eof, 1);

        // 1) basic 2x2
        set_case1();
        run_frame(2, 2, 1'b0, 1'b0);
        // 2) single row
        img[0][0] = 11; img[0][1] = 12;
        run_frame(2, 1, 1'b0, 1'b0);
        // 3) single pixel
        img[0][0] = 200;
        run_frame(1, 1, 1'b0, 1'b0);
        // 4) 2x2 under back-pressure
        set_case1();
        run_frame(2, 2, 1'b1, 1'b0);

        // 5) bad configurations, then a normal 3x2 frame with a start while busy
        do_start(0, 2);
        chk("cfg_w0_err", int'(cfg_err), 1);
        chk("cfg_w0_busy", int'(busy), 0);
        @(posedge clk); #1;
        chk("cfg_err_pulse_end", int'(cfg_err), 0);
        do_start(65, 2);
        chk("cfg_wmax_err", int'(cfg_err), 1);
        chk("cfg_wmax_busy", int'(busy), 0);
        img[0][0] = 1;   img[0][1] = 2;   img[0][2] = 255;
        img[1][0] = 101; img[1][1] = 150; img[1][2] = 255;
        run_frame(3, 2, 1'b0, 1'b1);

        // 6) reset mid-frame, then a full frame
        set_case1();
        build(2, 2);
        n_out = 0;
        do_start(2, 2);
        feed(2, 2);
        begin
            int k;
            k = 0;
            while (n_out < 5 && k < 500) begin k++; @(negedge clk); end
            chk("reset_wait_timeout", int'(n_out >= 5), 1);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        check_idle_outputs("midreset");
        reset = 1'b0;
        run_frame(2, 2, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
